// File: rtl/track_pkg.sv
// Shared types and defaults for the object-tracking sequencer.
package track_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TRACK  = 3'd1,
    ST_SEARCH = 3'd2,
    ST_MANUAL = 3'd3
  } state_t;

  localparam logic [7:0] CENTER_POS = 8'd128;

  localparam int COAST_TICKS_DEF = 16;
  localparam int SWEEP_STEP_DEF  = 8;
  localparam int SWEEP_MIN_DEF   = 16;
  localparam int SWEEP_MAX_DEF   = 240;
endpackage

// File: rtl/pos_filter.sv
// Position smoother: filt <= (3*filt + din) >> 2 on update, filt <= din on load.
// next_value is the combinational update result, so callers can register it alongside filt.
module pos_filter (
  input  logic       clk,
  input  logic       load,
  input  logic       update,
  input  logic [7:0] din,
  output logic [7:0] value,
  output logic [7:0] next_value
);
  logic [9:0] sum;

  // Largest possible sum is 3*255 + 255 = 1020, so ten bits never overflow.
  always_comb begin
    sum        = {2'b00, value} + {1'b0, value, 1'b0} + {2'b00, din};
    next_value = sum[9:2];
  end

  always_ff @(posedge clk) begin
    if (load) begin
      value <= din;
    end else if (update) begin
      value <= next_value;
    end
  end
endmodule

// File: rtl/track_sequencer.sv
// Sequencer that turns CNN detections, host overrides and a search sweep into a motor position.
// All outputs are registered; detections are accepted only while tracking or searching.
module track_sequencer
  import track_pkg::*;
#(
  parameter int COAST_TICKS = COAST_TICKS_DEF,
  parameter int SWEEP_STEP  = SWEEP_STEP_DEF,
  parameter int SWEEP_MIN   = SWEEP_MIN_DEF,
  parameter int SWEEP_MAX   = SWEEP_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       tick,
  input  logic       det_valid,
  output logic       det_ready,
  input  logic [7:0] det_pos,
  input  logic [7:0] det_conf,
  input  logic [7:0] conf_thresh,
  input  logic       host_req,
  input  logic [7:0] host_pos,
  output logic       host_grant,
  output logic [7:0] obj_pos_out,
  output logic       motor_en,
  output logic [2:0] state_out
);
  localparam int CW = $clog2(COAST_TICKS + 1);
  localparam logic [9:0] MIN10  = 10'(SWEEP_MIN);
  localparam logic [9:0] MAX10  = 10'(SWEEP_MAX);
  localparam logic [9:0] STEP10 = 10'(SWEEP_STEP);

  state_t        state;
  logic [CW-1:0] coast_cnt;
  logic          dir_right;
  logic          qual;
  logic          filt_load, filt_update;
  logic [7:0]    filt_din, filt_val, filt_next;
  logic [9:0]    pos10, up_sum, dn_sum;
  logic [7:0]    sweep_pos;
  logic          sweep_rev;

  assign state_out = state;
  assign qual      = det_valid && det_ready && (det_conf >= conf_thresh);

  // Filter returns to centre whenever the sequencer is idled, and is seeded by the first accepted hit.
  assign filt_load   = rst || !run || (!host_req && qual && state != ST_TRACK);
  assign filt_update = !rst && run && !host_req && qual && state == ST_TRACK;
  assign filt_din    = (rst || !run) ? CENTER_POS : det_pos;

  pos_filter u_filter (
    .clk        (clk),
    .load       (filt_load),
    .update     (filt_update),
    .din        (filt_din),
    .value      (filt_val),
    .next_value (filt_next)
  );

  // Sweep arithmetic in ten bits; a start point outside the bounds is pulled back inside.
  always_comb begin
    pos10     = {2'b00, obj_pos_out};
    up_sum    = pos10 + STEP10;
    dn_sum    = pos10 - STEP10;
    sweep_pos = obj_pos_out;
    sweep_rev = 1'b0;
    if (dir_right) begin
      if (up_sum >= MAX10) begin
        sweep_pos = MAX10[7:0];
        sweep_rev = 1'b1;
      end else if (up_sum < MIN10) begin
        sweep_pos = MIN10[7:0];
      end else begin
        sweep_pos = up_sum[7:0];
      end
    end else begin
      if (pos10 <= MIN10 + STEP10) begin
        sweep_pos = MIN10[7:0];
        sweep_rev = 1'b1;
      end else if (dn_sum > MAX10) begin
        sweep_pos = MAX10[7:0];
      end else begin
        sweep_pos = dn_sum[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      state       <= ST_IDLE;
      obj_pos_out <= CENTER_POS;
      motor_en    <= 1'b0;
      det_ready   <= 1'b0;
      host_grant  <= 1'b0;
      coast_cnt   <= '0;
      dir_right   <= 1'b1;
    end else if (host_req) begin
      state       <= ST_MANUAL;
      obj_pos_out <= host_pos;
      motor_en    <= 1'b1;
      det_ready   <= 1'b0;
      host_grant  <= 1'b1;
      coast_cnt   <= '0;
    end else begin
      motor_en   <= 1'b1;
      det_ready  <= 1'b1;
      host_grant <= 1'b0;
      case (state)
        ST_IDLE, ST_SEARCH: begin
          if (qual) begin
            state       <= ST_TRACK;
            obj_pos_out <= det_pos;
            coast_cnt   <= '0;
          end else if (state == ST_IDLE) begin
            state <= ST_SEARCH;
          end else if (tick) begin
            obj_pos_out <= sweep_pos;
            if (sweep_rev) dir_right <= ~dir_right;
          end
        end
        ST_TRACK: begin
          if (qual) begin
            obj_pos_out <= filt_next;
            coast_cnt   <= '0;
          end else if (tick) begin
            if (coast_cnt == CW'(COAST_TICKS - 1)) begin
              state     <= ST_SEARCH;
              coast_cnt <= '0;
              dir_right <= (filt_val <= CENTER_POS);
            end else begin
              coast_cnt <= coast_cnt + 1'b1;
            end
          end
        end
        ST_MANUAL: begin
          state     <= ST_SEARCH;
          coast_cnt <= '0;
          dir_right <= (obj_pos_out <= CENTER_POS);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
